// File: rtl/fifo_uart_tx.sv
// Drains the camera pixel FIFO and streams header-framed RGB565 bytes over an 8N1 UART.
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 43,
    parameter int unsigned IMAGE_PIXELS = 76800,
    parameter logic [7:0]  HEAD0        = 8'h01,
    parameter logic [7:0]  HEAD1        = 8'hFE
) (
    input  logic        S_CLK,
    input  logic        RST_N,
    input  logic [8:0]  r_usedw,
    input  logic [15:0] r_data,
    output logic        r_req,
    output logic        uart_txd,
    output logic        busy,
    output logic        frame_done
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned PIX_W = 17;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(IMAGE_PIXELS);

    typedef enum logic [3:0] {
        ST_IDLE, ST_HEAD0, ST_HEAD1, ST_FETCH, ST_LATCH,
        ST_SEND_H, ST_SEND_L, ST_TAIL0, ST_TAIL1, ST_DONE
    } state_t;

    state_t           state, state_nx, after_c;
    logic             loaded, loaded_nx;
    logic [15:0]      pix, pix_nx;
    logic [PIX_W-1:0] pix_cnt, cnt_nx;
    logic             req_nx, busy_nx, done_nx;

    logic             tx_active;
    logic [8:0]       tx_shift;
    logic [3:0]       tx_bit;
    logic [CNT_W-1:0] tx_cnt;
    logic             tx_done_c, tx_free_c, load_c;
    logic [7:0]       load_byte_c;

    // Byte carried by each send state; the trailer mirrors the header.
    function automatic logic [7:0] byte_of(input state_t st, input logic [15:0] px);
        case (st)
            ST_HEAD0, ST_TAIL1: byte_of = HEAD0;
            ST_HEAD1, ST_TAIL0: byte_of = HEAD1;
            ST_SEND_H:          byte_of = px[15:8];
            default:            byte_of = px[7:0];
        endcase
    endfunction

    function automatic logic is_send(input state_t st);
        is_send = (st == ST_HEAD0) || (st == ST_HEAD1) || (st == ST_SEND_H) ||
                  (st == ST_SEND_L) || (st == ST_TAIL0) || (st == ST_TAIL1);
    endfunction

    assign tx_done_c = tx_active && (tx_bit == 4'd9) && (tx_cnt == BIT_LAST);
    assign tx_free_c = !tx_active || tx_done_c;

    // 8N1 byte engine: bit 0 start, 1..8 data LSB first, 9 stop; reloads on tx_done for gapless bytes.
    always_ff @(posedge S_CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_active <= 1'b0;
            tx_shift  <= '1;
            tx_bit    <= '0;
            tx_cnt    <= '0;
            uart_txd  <= 1'b1;
        end else if (load_c && tx_free_c) begin
            tx_active <= 1'b1;
            tx_shift  <= {1'b1, load_byte_c};
            tx_bit    <= '0;
            tx_cnt    <= '0;
            uart_txd  <= 1'b0;
        end else if (tx_active) begin
            if (tx_cnt == BIT_LAST) begin
                tx_cnt <= '0;
                if (tx_bit == 4'd9) begin
                    tx_active <= 1'b0;
                end else begin
                    tx_bit   <= tx_bit + 4'd1;
                    uart_txd <= tx_shift[0];
                    tx_shift <= {1'b1, tx_shift[8:1]};
                end
            end else begin
                tx_cnt <= tx_cnt + CNT_W'(1);
            end
        end
    end

    // Frame FSM state and registered outputs.
    always_ff @(posedge S_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            loaded     <= 1'b0;
            pix        <= '0;
            pix_cnt    <= '0;
            r_req      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            loaded     <= loaded_nx;
            pix        <= pix_nx;
            pix_cnt    <= cnt_nx;
            r_req      <= req_nx;
            busy       <= busy_nx;
            frame_done <= done_nx;
        end
    end

    // Next state; a send state loads its byte once, then on tx_done hands the engine to the next byte.
    always_comb begin
        state_nx    = state;
        after_c     = state;
        loaded_nx   = loaded;
        pix_nx      = pix;
        cnt_nx      = pix_cnt;
        req_nx      = 1'b0;
        busy_nx     = busy;
        done_nx     = 1'b0;
        load_c      = 1'b0;
        load_byte_c = '0;
        case (state)
            ST_IDLE: begin
                if (r_usedw != '0) begin
                    state_nx = ST_HEAD0;
                    busy_nx  = 1'b1;
                end
            end
            ST_FETCH: begin
                if (r_usedw != '0) begin
                    req_nx   = 1'b1;
                    state_nx = ST_LATCH;
                end
            end
            ST_LATCH: begin
                // r_req is still high on the first LATCH cycle; data is valid on the next one.
                if (!r_req) begin
                    pix_nx   = r_data;
                    state_nx = ST_SEND_H;
                end
            end
            ST_DONE: begin
                done_nx  = 1'b1;
                busy_nx  = 1'b0;
                cnt_nx   = '0;
                state_nx = ST_IDLE;
            end
            default: begin
                if (!loaded) begin
                    if (tx_free_c) begin
                        load_c      = 1'b1;
                        load_byte_c = byte_of(state, pix);
                        loaded_nx   = 1'b1;
                    end
                end else if (tx_done_c) begin
                    case (state)
                        ST_HEAD0:  after_c = ST_HEAD1;
                        ST_HEAD1:  after_c = ST_FETCH;
                        ST_SEND_H: after_c = ST_SEND_L;
                        ST_SEND_L: begin
                            cnt_nx  = pix_cnt + PIX_W'(1);
                            after_c = (cnt_nx == PIX_LAST) ? ST_TAIL0 : ST_FETCH;
                        end
                        ST_TAIL0:  after_c = ST_TAIL1;
                        default:   after_c = ST_DONE;
                    endcase
                    state_nx = after_c;
                    if (is_send(after_c)) begin
                        load_c      = 1'b1;
                        load_byte_c = byte_of(after_c, pix);
                        loaded_nx   = 1'b1;
                    end else begin
                        loaded_nx   = 1'b0;
                    end
                end
            end
        endcase
    end

endmodule
